// File: rtl/mx_int8_sum_arb_if.sv
// Requester, datapath and response signal bundle for mx_int8_sum_arb.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mx_int8_sum_arb_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned SCALE_W    = 8
);
    localparam int unsigned RES_W = ELEM_W + $clog2(BLOCK_SIZE);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned VEC_W = BLOCK_SIZE * ELEM_W;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*SCALE_W-1:0] req_scale;
    logic [NUM_REQ*VEC_W-1:0]   req_elems;

    logic                       dp_in_valid;
    logic [SCALE_W-1:0]         dp_scale;
    logic [VEC_W-1:0]           dp_elems;
    logic                       dp_out_valid;
    logic [SCALE_W-1:0]         dp_out_scale;
    logic [RES_W-1:0]           dp_out_sum;
    logic                       dp_out_nan;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [SCALE_W-1:0]         rsp_scale;
    logic [RES_W-1:0]           rsp_sum;
    logic                       rsp_nan;
    logic                       err_lost;

    modport master (
        output req_valid, req_scale, req_elems,
        output dp_out_valid, dp_out_scale, dp_out_sum, dp_out_nan,
        output rsp_ready,
        input  req_ready, dp_in_valid, dp_scale, dp_elems,
        input  rsp_valid, rsp_id, rsp_scale, rsp_sum, rsp_nan, err_lost
    );

    modport slave (
        input  req_valid, req_scale, req_elems,
        input  dp_out_valid, dp_out_scale, dp_out_sum, dp_out_nan,
        input  rsp_ready,
        output req_ready, dp_in_valid, dp_scale, dp_elems,
        output rsp_valid, rsp_id, rsp_scale, rsp_sum, rsp_nan, err_lost
    );
endinterface

// File: rtl/mx_int8_sum_arb.sv
// Round-robin scheduler feeding one fixed-latency MXINT8 block-sum datapath.
// Results are tagged with requester id and queued in a credit-protected FIFO.
module mx_int8_sum_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned SCALE_W    = 8,
    parameter int unsigned SUM_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    mx_int8_sum_arb_if.slave  bus
);
    localparam int unsigned RES_W = ELEM_W + $clog2(BLOCK_SIZE);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned VEC_W = BLOCK_SIZE * ELEM_W;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id, cand;
    logic               grant_any, permitted, handshake;
    int unsigned        occ, idx;
    logic [SCALE_W-1:0] sel_scale;
    logic [VEC_W-1:0]   sel_elems;

    logic               issue_v_q;
    logic [ID_W-1:0]    issue_id_q;
    logic [SCALE_W-1:0] issue_scale_q;
    logic [VEC_W-1:0]   issue_elems_q;

    logic [SUM_LAT-1:0] tag_v_q;
    logic [ID_W-1:0]    tag_id_q [SUM_LAT];

    logic [ID_W-1:0]    mem_id    [FIFO_DEPTH];
    logic [SCALE_W-1:0] mem_scale [FIFO_DEPTH];
    logic [RES_W-1:0]   mem_sum   [FIFO_DEPTH];
    logic               mem_nan   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_lost_q;
    logic               slot_v, push, pop;

    // Every accepted vector holds a credit until its FIFO entry is popped.
    always_comb begin
        occ = 32'(cnt_q) + 32'(issue_v_q);
        for (int k = 0; k < SUM_LAT; k++) begin
            occ = occ + 32'(tag_v_q[k]);
        end
        permitted = occ < FIFO_DEPTH;
    end

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        handshake     = rst_n && permitted && grant_any;
        bus.req_ready = '0;
        if (handshake) begin
            bus.req_ready[grant_id] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        sel_scale = '0;
        sel_elems = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_scale = bus.req_scale[i*SCALE_W +: SCALE_W];
                sel_elems = bus.req_elems[i*VEC_W +: VEC_W];
            end
        end
    end

    // A result is only accepted in the slot its tag predicts; strays are dropped.
    assign slot_v = tag_v_q[SUM_LAT-1];
    assign push   = slot_v && bus.dp_out_valid;
    assign pop    = (cnt_q != '0) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            issue_v_q     <= 1'b0;
            issue_id_q    <= '0;
            issue_scale_q <= '0;
            issue_elems_q <= '0;
            tag_v_q       <= '0;
            for (int k = 0; k < SUM_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            err_lost_q    <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            issue_v_q <= handshake;
            if (handshake) begin
                issue_id_q    <= grant_id;
                issue_scale_q <= sel_scale;
                issue_elems_q <= sel_elems;
            end
            tag_v_q[0]  <= issue_v_q;
            tag_id_q[0] <= issue_id_q;
            for (int k = 1; k < SUM_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
            if (slot_v && !bus.dp_out_valid) begin
                err_lost_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q]    <= tag_id_q[SUM_LAT-1];
            mem_scale[wr_ptr_q] <= bus.dp_out_scale;
            mem_sum[wr_ptr_q]   <= bus.dp_out_sum;
            mem_nan[wr_ptr_q]   <= bus.dp_out_nan;
        end
    end

    always_comb begin
        bus.dp_in_valid = issue_v_q;
        bus.dp_scale    = issue_scale_q;
        bus.dp_elems    = issue_elems_q;
        bus.err_lost    = err_lost_q;
        bus.rsp_valid   = cnt_q != '0;
        bus.rsp_id      = '0;
        bus.rsp_scale   = '0;
        bus.rsp_sum     = '0;
        bus.rsp_nan     = 1'b0;
        if (cnt_q != '0) begin
            bus.rsp_id    = mem_id[rd_ptr_q];
            bus.rsp_scale = mem_scale[rd_ptr_q];
            bus.rsp_sum   = mem_sum[rd_ptr_q];
            bus.rsp_nan   = mem_nan[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_mx_int8_sum_arb.sv
// Bench for mx_int8_sum_arb: table vectors, directed corner sequences and random
// traffic against a queue-based model; includes a behavioural sum datapath.
module tb_mx_int8_sum_arb;
    localparam int NUM_REQ    = 4;
    localparam int BLOCK_SIZE = 32;
    localparam int ELEM_W     = 8;
    localparam int SCALE_W    = 8;
    localparam int SUM_LAT    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int RES_W      = ELEM_W + $clog2(BLOCK_SIZE);
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int VEC_W      = BLOCK_SIZE * ELEM_W;

    typedef struct {
        int               due;
        logic [ID_W-1:0]  id;
        logic [7:0]       scale;
        logic [RES_W-1:0] sum;
        logic             nan;
        logic             drop;
    } ent_t;

    typedef struct {
        logic [7:0] scale;
        logic [7:0] ea;
        logic [7:0] eb;
        int         exp_sum;
        logic       exp_nan;
    } tv_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mx_int8_sum_arb_if #(
        .NUM_REQ(NUM_REQ), .BLOCK_SIZE(BLOCK_SIZE), .ELEM_W(ELEM_W), .SCALE_W(SCALE_W)
    ) bus ();

    mx_int8_sum_arb #(
        .NUM_REQ(NUM_REQ), .BLOCK_SIZE(BLOCK_SIZE), .ELEM_W(ELEM_W), .SCALE_W(SCALE_W),
        .SUM_LAT(SUM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_rr = 0;
    int m_out = 0;
    logic m_err = 1'b0;
    int n_iss = 0;
    int drop_at = -1;
    int hs_obs = 0;
    int obs_g = -1;
    ent_t pend[$];
    ent_t vis[$];

    logic [NUM_REQ-1:0] drv_valid;
    logic               rdy;
    logic [SCALE_W-1:0] cur_scale [NUM_REQ];
    logic [VEC_W-1:0]   cur_vec   [NUM_REQ];
    tv_t                tab [8];
    logic [RES_W-1:0]   tab_sum;
    int                 hs0, exp_next;

    function automatic logic [RES_W-1:0] ref_sum(input logic [VEC_W-1:0] v);
        int s = 0;
        for (int j = 0; j < BLOCK_SIZE; j++) s += int'($signed(v[j*ELEM_W +: ELEM_W]));
        return RES_W'(s);
    endfunction

    function automatic logic ref_nan(input logic [SCALE_W-1:0] sc, input logic [VEC_W-1:0] v);
        logic n = (sc == 8'hFF);
        for (int j = 0; j < BLOCK_SIZE; j++) if (v[j*ELEM_W +: ELEM_W] == 8'h80) n = 1'b1;
        return n;
    endfunction

    // Behavioural datapath; deliberately not reset so stale results reach the DUT.
    logic [SUM_LAT-1:0] pv = '0;
    logic [SCALE_W-1:0] ps   [SUM_LAT];
    logic [RES_W-1:0]   psum [SUM_LAT];
    logic               pn   [SUM_LAT];
    int                 dp_cnt = 0;

    always @(posedge clk) begin
        for (int k = SUM_LAT - 1; k > 0; k--) begin
            pv[k]   <= pv[k-1];
            ps[k]   <= ps[k-1];
            psum[k] <= psum[k-1];
            pn[k]   <= pn[k-1];
        end
        pv[0]   <= (bus.dp_in_valid == 1'b1) && (dp_cnt != drop_at);
        ps[0]   <= bus.dp_scale;
        psum[0] <= ref_sum(bus.dp_elems);
        pn[0]   <= ref_nan(bus.dp_scale, bus.dp_elems);
        if (bus.dp_in_valid == 1'b1) dp_cnt <= dp_cnt + 1;
    end

    assign bus.dp_out_valid = pv[SUM_LAT-1];
    assign bus.dp_out_scale = ps[SUM_LAT-1];
    assign bus.dp_out_sum   = psum[SUM_LAT-1];
    assign bus.dp_out_nan   = pn[SUM_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic new_vec(input int i);
        cur_scale[i] = SCALE_W'($urandom_range(0, 255));
        for (int j = 0; j < BLOCK_SIZE; j++) cur_vec[i][j*ELEM_W +: ELEM_W] = 8'($urandom);
    endtask

    task automatic drive();
        bus.req_valid = drv_valid;
        bus.rsp_ready = rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_scale[i*SCALE_W +: SCALE_W] = cur_scale[i];
            bus.req_elems[i*VEC_W +: VEC_W]     = cur_vec[i];
        end
    endtask

    // One clock cycle: model prediction, compare at negedge, model update at the edge.
    task automatic step();
        ent_t e;
        int g;
        logic [NUM_REQ-1:0] er;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            e = pend.pop_front();
            if (e.drop) begin
                m_out--;
                m_err = 1'b1;
            end else begin
                vis.push_back(e);
            end
        end
        drive();
        g = -1;
        if (m_out < FIFO_DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int ix;
                ix = (m_rr + k) % NUM_REQ;
                if (g < 0 && drv_valid[ix]) g = ix;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        @(negedge clk);
        obs_g = -1;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] == 1'b1) obs_g = i;
        if ((bus.req_ready & bus.req_valid) != '0) hs_obs++;
        e = '{default: 0};
        if (vis.size() > 0) e = vis[0];
        check("req_ready", 64'(bus.req_ready), 64'(er));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(vis.size() > 0));
        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        check("rsp_scale", 64'(bus.rsp_scale), 64'(e.scale));
        check("rsp_sum", 64'(bus.rsp_sum), 64'(e.sum));
        check("rsp_nan", 64'(bus.rsp_nan), 64'(e.nan));
        check("err_lost", 64'(bus.err_lost), 64'(m_err));
        if (rdy && vis.size() > 0) begin
            void'(vis.pop_front());
            m_out--;
        end
        if (g >= 0) begin
            e.due   = cyc + SUM_LAT + 2;
            e.id    = ID_W'(g);
            e.scale = cur_scale[g];
            e.sum   = ref_sum(cur_vec[g]);
            e.nan   = ref_nan(cur_scale[g], cur_vec[g]);
            e.drop  = (n_iss == drop_at);
            pend.push_back(e);
            n_iss++;
            m_rr = (g + 1) % NUM_REQ;
            m_out++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (g >= 0) new_vec(g);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int c = 0; c < n; c++) begin
            drive();
            @(negedge clk);
            check("rst_req_ready", 64'(bus.req_ready), 64'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        pend.delete();
        vis.delete();
        m_out = 0;
        m_rr  = 0;
        m_err = 1'b0;
        check("rst_dp_valid", 64'(bus.dp_in_valid), 64'd0);
        check("rst_dp_scale", 64'(bus.dp_scale), 64'd0);
        check("rst_dp_elems", 64'(|bus.dp_elems), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_err_lost", 64'(bus.err_lost), 64'd0);
    endtask

    task automatic idle(input int n);
        drv_valid = '0;
        rdy = 1'b1;
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        tab[0] = '{8'h7F, 8'h01, 8'h01,    32, 1'b0};
        tab[1] = '{8'h7F, 8'hFF, 8'hFF,   -32, 1'b0};
        tab[2] = '{8'h00, 8'h7F, 8'h7F,  4064, 1'b0};
        tab[3] = '{8'h10, 8'h80, 8'h80, -4096, 1'b1};
        tab[4] = '{8'hFF, 8'h00, 8'h00,     0, 1'b1};
        tab[5] = '{8'h7F, 8'h7F, 8'h81,     0, 1'b0};
        tab[6] = '{8'h3C, 8'h05, 8'hFE,    48, 1'b0};
        tab[7] = '{8'h01, 8'h80, 8'h7F,   -16, 1'b1};

        drv_valid = '0;
        rdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) new_vec(i);
        do_reset(2);

        // Table vectors through requester 0 with exact response latency.
        for (int t = 0; t < 8; t++) begin
            cur_scale[0] = tab[t].scale;
            for (int j = 0; j < BLOCK_SIZE; j++)
                cur_vec[0][j*ELEM_W +: ELEM_W] = (j % 2 == 0) ? tab[t].ea : tab[t].eb;
            drv_valid = 4'b0001;
            step();
            drv_valid = '0;
            for (int c = 0; c < SUM_LAT + 1; c++) step();
            tab_sum = RES_W'(tab[t].exp_sum);
            check("tab_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("tab_rsp_id", 64'(bus.rsp_id), 64'd0);
            check("tab_rsp_scale", 64'(bus.rsp_scale), 64'(tab[t].scale));
            check("tab_rsp_sum", 64'(bus.rsp_sum), 64'(tab_sum));
            check("tab_rsp_nan", 64'(bus.rsp_nan), 64'(tab[t].exp_nan));
            step();
        end

        // All requesters busy: grants rotate starting after requester 0.
        drv_valid = 4'hF;
        rdy = 1'b1;
        exp_next = 1;
        for (int c = 0; c < 16; c++) begin
            step();
            if (obs_g >= 0) begin
                check("rr_order", 64'(obs_g), 64'(exp_next));
                exp_next = (exp_next + 1) % NUM_REQ;
            end
        end
        idle(10);

        // Stalled consumer: credits stop issue at FIFO_DEPTH.
        drv_valid = 4'hF;
        rdy = 1'b0;
        hs0 = hs_obs;
        for (int c = 0; c < 10; c++) step();
        check("credit_limit", 64'(hs_obs - hs0), 64'(FIFO_DEPTH));
        check("full_req_ready", 64'(bus.req_ready), 64'd0);
        for (int c = 0; c < 40; c++) begin
            rdy = ($urandom_range(0, 1) == 1);
            step();
        end
        idle(10);

        // Lost datapath result: sticky error, credit recovered.
        drop_at = n_iss;
        drv_valid = 4'b0010;
        step();
        idle(SUM_LAT + 3);
        check("err_lost_set", 64'(bus.err_lost), 64'd1);
        drv_valid = 4'b0010;
        step();
        idle(SUM_LAT + 3);
        check("err_lost_sticky", 64'(bus.err_lost), 64'd1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            drv_valid = NUM_REQ'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(10);

        // Reset with vectors in flight; late datapath results must be ignored.
        drv_valid = 4'hF;
        rdy = 1'b1;
        for (int c = 0; c < 3; c++) step();
        do_reset(1);
        idle(SUM_LAT + 4);
        drv_valid = 4'hF;
        step();
        check("rst_rr_first", 64'(obs_g), 64'd0);
        for (int c = 0; c < 6; c++) step();
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
